tcbm_link_sequencer: RTL and testbench
======================================

TCBM_LINK_SEQUENCER -- requirements
Module: tcbm_link_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, number of cycles data is held on the port before DAV asserts (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4095, maximum cycles spent waiting for any single ACK edge (12-bit, 1..4095).
REQ-003 SHALL have parameter CMD_CODE, default 8'h81, code byte sent ahead of every command byte.
REQ-004 SHALL have port: phi2 in 1, the single clock; all logic is rising-edge phi2.
REQ-005 SHALL have port: reset in 1, asynchronous, active-high reset.
REQ-006 SHALL have port: start in 1, one-cycle request to begin an operation; sampled only in IDLE.
REQ-007 SHALL have port: op in 2, operation code: 00 write data, 01 write command, 10 read byte, 11 reserved.
REQ-008 SHALL have port: tx_data in 8, byte to write; captured when start is accepted.
REQ-009 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky).
REQ-010 SHALL have ports: rx_data out 8; rx_status out 2, byte and status captured by a read.
REQ-011 SHALL have ports: pa_out out 8, pa_oe out 1, pa_in in 8, the data-port drive, enable and pins.
REQ-012 SHALL have ports: st_in in 2, status pins; dav_n out 1, data-valid strobe to drive; ack_n in 1, asynchronous acknowledge from drive.

Function
REQ-013 SHALL pass ack_n through a 2-flop synchronizer; all ACK decisions use the synchronized value (ack_s).
REQ-014 SHALL implement states IDLE, SETUP, DAV_LO, DAV_HI, ERR.
REQ-015 SHALL accept start only in IDLE; start outside IDLE, or with op=11, SHALL be ignored (op=11 produces no busy, no done).
REQ-016 On acceptance SHALL capture op and tx_data, assert busy the next cycle, and stay busy until the cycle done or err rises.
REQ-017 Write (op 00): pa_oe=1, pa_out=tx_data; SETUP for SETUP_CYCLES cycles; DAV_LO: dav_n=0 until ack_s=0; DAV_HI: dav_n=1 until ack_s=1; then done.
REQ-018 Write command (op 01): SHALL run a full write of CMD_CODE, then a full write of tx_data, with a single done at the end; busy SHALL not drop between the two bytes.
REQ-019 Read (op 10): pa_oe=0 throughout; SETUP for SETUP_CYCLES; DAV_LO until ack_s=0, then capture pa_in into rx_data and st_in into rx_status on that same cycle; DAV_HI until ack_s=1; then done.
REQ-020 pa_out/pa_oe SHALL remain stable from SETUP entry until DAV_HI completes; pa_oe=0 in IDLE and ERR.
REQ-021 A 12-bit timeout counter SHALL clear on entry to DAV_LO and DAV_HI and increment each waiting cycle; reaching TIMEOUT_CYCLES SHALL enter ERR.
REQ-022 ERR: dav_n=1, pa_oe=0, busy=0, err=1, no done; SHALL return to IDLE the next cycle; err stays set until the next accepted start clears it.
REQ-023 If ack_s is already 0 on entry to SETUP, SHALL still complete SETUP, then proceed through DAV_LO in one cycle (no wait for a new falling edge).
REQ-024 rx_data/rx_status SHALL hold their last captured values until the next read capture; writes SHALL not alter them.
REQ-025 done SHALL be a one-cycle pulse in the cycle after the final ACK-high detection; start in that same cycle is ignored, and start is accepted from the next cycle.

Reset
REQ-026 When reset=1: state=IDLE, dav_n=1, pa_oe=0, pa_out=0, busy=0, done=0, err=0, rx_data=0, rx_status=0, synchronizer flops=1, timeout counter=0.
REQ-027 Reset asserted mid-operation SHALL release dav_n and pa_oe immediately (asynchronously), with no done or err pulse.

Verification
REQ-028 Write 8'h5A, drive model ACKs 3 cycles after DAV low and releases 3 cycles after DAV high -> pa_out=5A with pa_oe=1 for 2 cycles before dav_n=0; one done; err=0.
REQ-029 Command op, tx_data=8'h12 -> two DAV strobes carrying 81 then 12; busy continuous; exactly one done.
REQ-030 Read with pa_in=8'hC3, st_in=2'b10 set before ACK low -> rx_data=C3, rx_status=10 after done; pa_oe never 1.
REQ-031 TIMEOUT_CYCLES=16, drive never ACKs -> ERR 16 cycles after dav_n=0; err=1, dav_n=1, busy=0, no done; the next start clears err.
REQ-032 Reset pulsed while in DAV_LO -> dav_n=1, pa_oe=0 in the same cycle; the following start runs normally.
REQ-033 start held high through a whole write, plus op=11 pulses -> exactly one operation per IDLE acceptance; op=11 yields no busy.

Source files
------------

// File: rtl/tcbm_link_sequencer.sv
// TCBM link sequencer: drives byte writes, command writes and byte reads over a
// DAV/ACK handshake, with a per-edge ACK timeout and a sticky error flag.
module tcbm_link_sequencer #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter logic [7:0]  CMD_CODE       = 8'h81
) (
  input  logic       phi2,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rx_data,
  output logic [1:0] rx_status,
  output logic [7:0] pa_out,
  output logic       pa_oe,
  input  logic [7:0] pa_in,
  input  logic [1:0] st_in,
  output logic       dav_n,
  input  logic       ack_n
);

  localparam logic [11:0] SETUP_LAST    = 12'(SETUP_CYCLES - 1);
  localparam logic [11:0] TIMEOUT_LIMIT = 12'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DAV_LO,
    S_DAV_HI,
    S_ERR
  } state_t;

  state_t      r_state, w_state_next;
  logic [11:0] r_cnt, w_cnt_next;
  logic        r_is_read, w_is_read_next;
  logic        r_cmd_pending, w_cmd_pending_next;
  logic [7:0]  r_tx, w_tx_next;
  logic [7:0]  r_pa_out, w_pa_out_next;
  logic        r_done, w_done_next;
  logic        r_err, w_err_next;
  logic [7:0]  r_rx_data, w_rx_data_next;
  logic [1:0]  r_rx_status, w_rx_status_next;
  logic        r_ack_meta, r_ack_s;
  logic [11:0] w_cnt_inc;
  logic        w_accept;
  logic        w_active;

  always_ff @(posedge phi2 or posedge reset) begin
    if (reset) begin
      r_ack_meta <= 1'b1;
      r_ack_s    <= 1'b1;
    end else begin
      r_ack_meta <= ack_n;
      r_ack_s    <= r_ack_meta;
    end
  end

  always_ff @(posedge phi2 or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_is_read     <= 1'b0;
      r_cmd_pending <= 1'b0;
      r_tx          <= '0;
      r_pa_out      <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_rx_data     <= '0;
      r_rx_status   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_is_read     <= w_is_read_next;
      r_cmd_pending <= w_cmd_pending_next;
      r_tx          <= w_tx_next;
      r_pa_out      <= w_pa_out_next;
      r_done        <= w_done_next;
      r_err         <= w_err_next;
      r_rx_data     <= w_rx_data_next;
      r_rx_status   <= w_rx_status_next;
    end
  end

  // The done cycle is still IDLE but must not accept a new start.
  assign w_accept  = start && !r_done && (op != 2'b11);
  assign w_cnt_inc = r_cnt + 12'd1;

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_is_read_next     = r_is_read;
    w_cmd_pending_next = r_cmd_pending;
    w_tx_next          = r_tx;
    w_pa_out_next      = r_pa_out;
    w_done_next        = 1'b0;
    w_err_next         = r_err;
    w_rx_data_next     = r_rx_data;
    w_rx_status_next   = r_rx_status;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next       = S_SETUP;
          w_cnt_next         = '0;
          w_err_next         = 1'b0;
          w_tx_next          = tx_data;
          w_is_read_next     = (op == 2'b10);
          w_cmd_pending_next = (op == 2'b01);
          if (op == 2'b01) begin
            w_pa_out_next = CMD_CODE;
          end else if (op == 2'b00) begin
            w_pa_out_next = tx_data;
          end
        end
      end

      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_next = S_DAV_LO;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      S_DAV_LO: begin
        if (!r_ack_s) begin
          w_state_next = S_DAV_HI;
          w_cnt_next   = '0;
          if (r_is_read) begin
            w_rx_data_next   = pa_in;
            w_rx_status_next = st_in;
          end
        end else if (w_cnt_inc == TIMEOUT_LIMIT) begin
          w_state_next = S_ERR;
          w_cnt_next   = w_cnt_inc;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      S_DAV_HI: begin
        if (r_ack_s) begin
          w_cnt_next = '0;
          // A command write chains straight into the data byte without leaving busy.
          if (r_cmd_pending) begin
            w_state_next       = S_SETUP;
            w_cmd_pending_next = 1'b0;
            w_pa_out_next      = r_tx;
          end else begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end
        end else if (w_cnt_inc == TIMEOUT_LIMIT) begin
          w_state_next = S_ERR;
          w_cnt_next   = w_cnt_inc;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      S_ERR: begin
        w_state_next       = S_IDLE;
        w_cmd_pending_next = 1'b0;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decode directly from state so reset releases them at once.
  assign w_active  = (r_state == S_SETUP) || (r_state == S_DAV_LO) || (r_state == S_DAV_HI);
  assign busy      = w_active;
  assign dav_n     = (r_state != S_DAV_LO);
  assign pa_oe     = w_active && !r_is_read;
  assign pa_out    = r_pa_out;
  assign done      = r_done;
  assign err       = r_err;
  assign rx_data   = r_rx_data;
  assign rx_status = r_rx_status;

endmodule

// File: tb/tb_tcbm_link_sequencer.sv
// Randomized bench for tcbm_link_sequencer: a reactive drive model answers DAV,
// and per-operation expectations are derived from byte lists and latency arithmetic.
module tb_tcbm_link_sequencer;

  localparam int unsigned SETUP_N = 2;
  localparam int unsigned TMO_N   = 16;
  localparam logic [7:0]  CMD     = 8'h81;

  logic       phi2 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = '0;
  logic [7:0] tx_data = '0;
  logic [7:0] pa_in = '0;
  logic [1:0] st_in = '0;
  logic       ack_n = 1'b1;
  logic       busy, done, err, pa_oe, dav_n;
  logic [7:0] rx_data, pa_out;
  logic [1:0] rx_status;

  tcbm_link_sequencer #(
    .SETUP_CYCLES  (SETUP_N),
    .TIMEOUT_CYCLES(TMO_N),
    .CMD_CODE      (CMD)
  ) dut (
    .phi2     (phi2),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rx_data  (rx_data),
    .rx_status(rx_status),
    .pa_out   (pa_out),
    .pa_oe    (pa_oe),
    .pa_in    (pa_in),
    .st_in    (st_in),
    .dav_n    (dav_n),
    .ack_n    (ack_n)
  );

  always #5 phi2 = ~phi2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor state
  int         cyc = 0;
  logic       prev_dav_n = 1'b1, prev_busy = 1'b0, prev_err = 1'b0;
  logic [7:0] strobes[$];
  int         lo_len[$];
  int         cur_lo, n_done, n_busy_rise, setup_len, err_rise;
  int         first_done_cyc, rise2_cyc, done_lat;
  bit         counting, oe_any, oe_miss;
  logic       err_at_rise, err_busy, err_dav, err_oe;

  // drive model state
  bit ack_en = 1'b0;
  bit strobed = 1'b0;
  int ack_dly, rel_dly, lo_cnt, hi_cnt, rel_cyc;

  // expected persistent state
  logic [7:0] exp_rx  = '0;
  logic [1:0] exp_st  = '0;
  logic       exp_err = 1'b0;

  task automatic clr_mon();
    strobes.delete();
    lo_len.delete();
    cur_lo = 0; n_done = 0; n_busy_rise = 0; setup_len = 0; err_rise = 0;
    first_done_cyc = 0; rise2_cyc = 0; done_lat = -1;
    counting = 0; oe_any = 0; oe_miss = 0;
    err_at_rise = 1'bx; err_busy = 1'bx; err_dav = 1'bx; err_oe = 1'bx;
  endtask

  task automatic cycle();
    @(negedge phi2);
    cyc++;
    if (busy && !prev_busy) begin
      n_busy_rise++;
      if (n_busy_rise == 1) begin
        counting    = 1;
        setup_len   = 0;
        err_at_rise = err;
      end else begin
        rise2_cyc = cyc;
      end
    end
    if (counting) begin
      if (!dav_n) counting = 0;
      else        setup_len++;
    end
    if (!dav_n && prev_dav_n) begin
      strobes.push_back(pa_out);
      cur_lo = 0;
    end
    if (!dav_n) cur_lo++;
    if (dav_n && !prev_dav_n) lo_len.push_back(cur_lo);
    if (busy && pa_oe)  oe_any  = 1;
    if (busy && !pa_oe) oe_miss = 1;
    if (done) begin
      n_done++;
      if (n_done == 1) first_done_cyc = cyc;
      done_lat = cyc - rel_cyc;
    end
    if (err && !prev_err) begin
      err_rise++;
      err_busy = busy;
      err_dav  = dav_n;
      err_oe   = pa_oe;
    end
    prev_dav_n = dav_n;
    prev_busy  = busy;
    prev_err   = err;

    // drive responds to DAV edges after programmable delays
    if (ack_en) begin
      if (!dav_n && ack_n) begin
        lo_cnt++;
        if (lo_cnt >= ack_dly) begin
          ack_n  = 1'b0;
          lo_cnt = 0;
        end
      end else if (dav_n && !ack_n && strobed) begin
        hi_cnt++;
        if (hi_cnt >= rel_dly) begin
          ack_n   = 1'b1;
          hi_cnt  = 0;
          strobed = 0;
          rel_cyc = cyc;
        end
      end
    end
    if (!dav_n) strobed = 1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [7:0] d, input logic [7:0] pin,
                        input logic [1:0] sin, input int ad, input int rd,
                        input bit en, input bit pre, input bit junk, input bit hold);
    int         exp_ops;
    bit         to_case;
    logic [7:0] exp_q[$];
    exp_ops = (o == 2'b11) ? 0 : (hold ? 2 : 1);
    to_case = !en && !pre && (o != 2'b11);
    pa_in   = pin;
    st_in   = sin;
    ack_dly = ad; rel_dly = rd; ack_en = en;
    lo_cnt  = 0; hi_cnt = 0; strobed = 0;
    if (pre) begin
      ack_n = 1'b0;
      repeat (3) cycle();
    end
    clr_mon();
    op = o; tx_data = d; start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (hold) begin
        start = (n_busy_rise < 2);
      end else begin
        start = 1'b0;
        if (junk && busy && ($urandom_range(0, 3) == 0)) begin
          start   = 1'b1;
          op      = 2'($urandom);
          tx_data = 8'($urandom);
        end
      end
      if ((n_done >= exp_ops) || (err_rise > 0)) break;
    end
    start = 1'b0;
    repeat (5) cycle();
    if (pre) begin
      ack_n = 1'b1;
      repeat (2) cycle();
    end

    for (int k = 0; k < exp_ops; k++) begin
      if (o == 2'b01) exp_q.push_back(CMD);
      exp_q.push_back(d);
    end

    if (to_case) begin
      chk("tmo_err_rise", err_rise, 1);
      chk("tmo_no_done", n_done, 0);
      chk("tmo_busy", {31'd0, err_busy}, 0);
      chk("tmo_dav_n", {31'd0, err_dav}, 1);
      chk("tmo_pa_oe", {31'd0, err_oe}, 0);
      chk("tmo_lo_len", (lo_len.size() > 0) ? lo_len[0] : -1, TMO_N);
      chk("tmo_err_sticky", {31'd0, err}, 1);
      exp_err = 1'b1;
    end else begin
      chk("done_count", n_done, exp_ops);
      chk("busy_rises", n_busy_rise, exp_ops);
      chk("strobe_count", strobes.size(), exp_q.size());
      if (o != 2'b10) begin
        foreach (exp_q[k]) begin
          if (k < strobes.size()) chk("strobe_byte", strobes[k], exp_q[k]);
        end
      end
      if (exp_ops > 0) begin
        exp_err = 1'b0;
        chk("setup_len", setup_len, SETUP_N);
        chk("err_cleared", {31'd0, err_at_rise}, 0);
        chk("dav_lo_len", (lo_len.size() > 0) ? lo_len[0] : -1, pre ? 1 : ad + 2);
        chk("done_latency", done_lat, 3);
        if (o == 2'b10) begin
          chk("read_oe", oe_any, 0);
          exp_rx = pin;
          exp_st = sin;
        end else begin
          chk("write_oe", oe_miss, 0);
        end
      end
      if (hold) chk("restart_gap", rise2_cyc - first_done_cyc, 2);
      chk("err_flag", {31'd0, err}, {31'd0, exp_err});
    end
    chk("rx_data", rx_data, exp_rx);
    chk("rx_status", rx_status, exp_st);
  endtask

  task automatic reset_mid_op();
    bit hit;
    hit    = 0;
    ack_en = 0;
    ack_n  = 1'b1;
    op = 2'b00; tx_data = 8'($urandom); start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      if (!dav_n) hit = 1;
    end
    chk("rst_reached_dav_lo", hit, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_dav_n", dav_n, 1);
    chk("rst_pa_oe", pa_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pa_out", pa_out, 0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_after_done", done, 0);
    chk("rst_after_err", err, 0);
    exp_rx = '0; exp_st = '0; exp_err = 1'b0;
  endtask

  initial begin
    bit en, pre;
    cycle();
    cycle();
    chk("reset_dav_n", dav_n, 1);
    chk("reset_pa_oe", pa_oe, 0);
    chk("reset_pa_out", pa_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_status", rx_status, 0);
    reset = 1'b0;
    cycle();

    run_op(2'b00, 8'h5A, 8'h00, 2'b00, 3, 3, 1, 0, 0, 0);
    run_op(2'b01, 8'h12, 8'h00, 2'b00, 2, 2, 1, 0, 0, 0);
    run_op(2'b10, 8'h00, 8'hC3, 2'b10, 4, 2, 1, 0, 0, 0);
    run_op(2'b00, 8'h77, 8'h11, 2'b01, 3, 3, 1, 0, 0, 0);
    run_op(2'b00, 8'hAA, 8'h00, 2'b00, 1, 1, 0, 0, 0, 0);
    run_op(2'b00, 8'h55, 8'h00, 2'b00, 2, 2, 1, 0, 0, 0);
    run_op(2'b10, 8'h00, 8'h3E, 2'b01, 1, 2, 1, 1, 0, 0);
    run_op(2'b00, 8'h3C, 8'h00, 2'b00, 2, 3, 1, 0, 0, 1);
    run_op(2'b11, 8'hFF, 8'h00, 2'b00, 1, 1, 1, 0, 0, 0);
    run_op(2'b01, 8'h9D, 8'h00, 2'b00, 1, 4, 1, 0, 1, 0);
    reset_mid_op();
    run_op(2'b00, 8'hE1, 8'h00, 2'b00, 2, 2, 1, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      en  = ($urandom_range(0, 7) != 0);
      pre = en && ($urandom_range(0, 5) == 0);
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 2'($urandom),
             $urandom_range(1, 8), $urandom_range(1, 8), en, pre,
             bit'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
